// File: rtl/speed_ctrl.sv
// speed_ctrl: control FSM for the roadside speed trap.
// Conditions the two raw sensors (2-flop synchronizer, optional debounce,
// registered rising-edge detect), sequences the datapath strobes, captures
// the measured speed and opens or keeps closed the barrier.
// Optional feature macro: SPEED_CTRL_DEBOUNCE_EN (per-sensor stability filter).
module speed_ctrl #(
  parameter int WIDTH_SPEED  = 14,
  parameter int SPEED_LIMIT  = 60,
  parameter int DEB_CYCLES   = 1000,
  parameter int TIMEOUT_CYC  = 20000000,
  parameter int DONE_TIMEOUT = 64,
  parameter int HOLD_CYC     = 30000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sen1_in,
  input  logic                   sen2_in,
  input  logic                   done,
  input  logic [WIDTH_SPEED-1:0] speed,
  output logic                   init,
  output logic                   count,
  output logic                   cal,
  output logic                   en,
  output logic                   dis,
  output logic [WIDTH_SPEED-1:0] speed_q,
  output logic                   over_speed,
  output logic                   timeout_err,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEASURE = 3'd1,
    CALC    = 3'd2,
    OPEN    = 3'd3,
    CLOSE   = 3'd4
  } state_t;

  // One shared timer serves both the MEASURE timeout and the CALC done-wait,
  // so it is sized for the larger of the two limits.
  localparam int TMR_MAX = (TIMEOUT_CYC > DONE_TIMEOUT) ? TIMEOUT_CYC : DONE_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);

  logic [1:0]        s1_sync;
  logic [1:0]        s2_sync;
  logic              s1_lvl;
  logic              s2_lvl;
  logic              s1_lvl_d;
  logic              s2_lvl_d;
  logic              s1_rise;
  logic              s2_rise;
  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [HOLD_W-1:0] hold_cnt;

  // Two-flop synchronizers bring the asynchronous sensor levels into clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sync <= '0;
      s2_sync <= '0;
    end else begin
      s1_sync <= {s1_sync[0], sen1_in};
      s2_sync <= {s2_sync[0], sen2_in};
    end
  end

`ifdef SPEED_CTRL_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] s1_deb_cnt;
  logic [DEB_W-1:0] s2_deb_cnt;

  // Accept a new synchronized level only after it has differed from the
  // accepted level for DEB_CYCLES consecutive cycles; any return resets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_lvl     <= 1'b0;
      s2_lvl     <= 1'b0;
      s1_deb_cnt <= '0;
      s2_deb_cnt <= '0;
    end else begin
      if (s1_sync[1] == s1_lvl) begin
        s1_deb_cnt <= '0;
      end else if (s1_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        s1_lvl     <= s1_sync[1];
        s1_deb_cnt <= '0;
      end else begin
        s1_deb_cnt <= s1_deb_cnt + DEB_W'(1);
      end

      if (s2_sync[1] == s2_lvl) begin
        s2_deb_cnt <= '0;
      end else if (s2_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        s2_lvl     <= s2_sync[1];
        s2_deb_cnt <= '0;
      end else begin
        s2_deb_cnt <= s2_deb_cnt + DEB_W'(1);
      end
    end
  end
`else
  assign s1_lvl = s1_sync[1];
  assign s2_lvl = s2_sync[1];
`endif

  // Registered rising-edge detectors give one-cycle s1_rise / s2_rise pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_lvl_d <= 1'b0;
      s2_lvl_d <= 1'b0;
      s1_rise  <= 1'b0;
      s2_rise  <= 1'b0;
    end else begin
      s1_lvl_d <= s1_lvl;
      s2_lvl_d <= s2_lvl;
      s1_rise  <= s1_lvl & ~s1_lvl_d;
      s2_rise  <= s2_lvl & ~s2_lvl_d;
    end
  end

  // Main sequencer; every output is a register written only here. CLOSE
  // raises dis on entry if the previous state did not already do so.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      hold_cnt    <= '0;
      init        <= 1'b0;
      count       <= 1'b0;
      cal         <= 1'b0;
      en          <= 1'b0;
      dis         <= 1'b0;
      speed_q     <= '0;
      over_speed  <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      init        <= 1'b0;
      cal         <= 1'b0;
      en          <= 1'b0;
      dis         <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (s1_rise) begin
            state      <= MEASURE;
            init       <= 1'b1;
            over_speed <= 1'b0;
            timer      <= '0;
            busy       <= 1'b1;
          end
        end

        MEASURE: begin
          if (s2_rise) begin
            state <= CALC;
            count <= 1'b0;
            cal   <= 1'b1;
            timer <= '0;
          end else if (timer == TMR_W'(TIMEOUT_CYC)) begin
            state       <= IDLE;
            count       <= 1'b0;
            timeout_err <= 1'b1;
            dis         <= 1'b1;
            timer       <= '0;
            busy        <= 1'b0;
          end else begin
            count <= 1'b1;
            timer <= timer + TMR_W'(1);
          end
        end

        CALC: begin
          if (done) begin
            speed_q <= speed;
            timer   <= '0;
            if (speed <= WIDTH_SPEED'(SPEED_LIMIT)) begin
              state    <= OPEN;
              en       <= 1'b1;
              hold_cnt <= '0;
            end else begin
              state      <= CLOSE;
              over_speed <= 1'b1;
              dis        <= 1'b1;
            end
          end else if (timer == TMR_W'(DONE_TIMEOUT - 1)) begin
            state       <= CLOSE;
            timeout_err <= 1'b1;
            timer       <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        OPEN: begin
          if (hold_cnt == HOLD_W'(HOLD_CYC)) begin
            state <= CLOSE;
            dis   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        CLOSE: begin
          if (dis) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dis <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          count <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
